sync_fifo: RTL

- Single-clock, parametrised FIFO: storage plus full pointer/flag control in one block.
- Generalises the team's existing FIFO storage element with:
  - built-in pointer management;
  - occupancy count;
  - programmable almost-full/almost-empty thresholds;
  - selectable read mode (registered or show-ahead);
  - sticky overflow/underflow error flags.
- Used for intra-domain buffering between producer/consumer stages, e.g. the UART/ALU register paths, where no clock crossing is needed.

---
 rtl/sync_fifo_pkg.sv | 16 +
 rtl/sync_fifo_ram.sv | 24 ++
 rtl/sync_fifo.sv | 138 +++++++++++++
 3 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers and read-mode constants for the sync_fifo block.
package sync_fifo_pkg;

    localparam int RD_REGISTERED = 0;
    localparam int RD_SHOW_AHEAD = 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic int depth_of(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage: clocked write port, combinational read port, no reset.
module sync_fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, threshold flags, sticky error flags
// and a choice of registered or show-ahead read.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AFULL_TH   = 2**ADDR_WIDTH - 2,
    parameter int AEMPTY_TH  = 2,
    parameter int SHOW_AHEAD = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam int DEPTH = depth_of(ADDR_WIDTH);
    localparam int PW    = ptr_width(ADDR_WIDTH);
    localparam int AF_CL = (AFULL_TH < 0) ? 0 : ((AFULL_TH > DEPTH) ? DEPTH : AFULL_TH);
    localparam int AE_CL = (AEMPTY_TH < 0) ? 0 : ((AEMPTY_TH > DEPTH) ? DEPTH : AEMPTY_TH);
    localparam logic [PW-1:0] AF_TH = PW'(AF_CL);
    localparam logic [PW-1:0] AE_TH = PW'(AE_CL);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q, count_d;
    logic          full_q, empty_q, afull_q, aempty_q;
    logic          overflow_q, underflow_q;
    logic          wr_acc, rd_acc;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // Acceptance uses the flags as they stood at the start of the cycle.
    assign wr_acc = wr_en & ~full_q;
    assign rd_acc = rd_en & ~empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(wr_acc);
        rd_ptr_d = rd_ptr_q + PW'(rd_acc);
        count_d  = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + PW'(1);
            2'b01:   count_d = count_q - PW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            afull_q     <= (AF_CL == 0);
            aempty_q    <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (wr_ptr_d[PW-1] != rd_ptr_d[PW-1]) &&
                        (wr_ptr_d[PW-2:0] == rd_ptr_d[PW-2:0]);
            empty_q  <= (wr_ptr_d == rd_ptr_d);
            afull_q  <= (count_d >= AF_TH);
            aempty_q <= (count_d <= AE_TH);
            // A new error event wins over a clear arriving in the same cycle.
            if (wr_en && full_q) begin
                overflow_q <= 1'b1;
            end else if (clr_err) begin
                overflow_q <= 1'b0;
            end
            if (rd_en && empty_q) begin
                underflow_q <= 1'b1;
            end else if (clr_err) begin
                underflow_q <= 1'b0;
            end
        end
    end

    sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wdata (wr_data),
        .raddr (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rdata (ram_rdata)
    );

    generate
        if (SHOW_AHEAD == RD_SHOW_AHEAD) begin : g_show_ahead
            assign rd_data  = ram_rdata;
            assign rd_valid = ~empty_q;
        end else begin : g_registered
            logic [DATA_WIDTH-1:0] rd_data_q;
            logic                  rd_valid_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_acc;
                    if (rd_acc) begin
                        rd_data_q <= ram_rdata;
                    end
                end
            end

            assign rd_data  = rd_data_q;
            assign rd_valid = rd_valid_q;
        end
    endgenerate

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule
